// File: rtl/rvc_asap_pkg.sv
// +---------------------------------------------------------------------------+
// | rvc_asap_pkg: shared types and size defaults for the RVC memory controller |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

package rvc_asap_pkg;

  localparam int c_I_MEM_BYTES = 4096;
  localparam int c_D_MEM_BYTES = 8192;
  localparam int c_RD_LAT      = 2;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } t_mem_size;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } t_dmem_state;

endpackage

`default_nettype wire

// File: rtl/rvc_ld_align.sv
// +---------------------------------------------------------------------------+
// | rvc_ld_align: extracts a byte/half/word from a D_MEM word and extends it   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module rvc_ld_align
  import rvc_asap_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [31:0] w_shift;

  assign w_shift = raw >> {addr, 3'b000};

  always_comb begin
    result = '0;
    case (t_mem_size'(size))
      BYTE:    result = sign ? {{24{w_shift[7]}}, w_shift[7:0]}
                             : {24'b0, w_shift[7:0]};
      HALF:    result = sign ? {{16{w_shift[15]}}, w_shift[15:0]}
                             : {16'b0, w_shift[15:0]};
      WORD:    result = w_shift;
      default: result = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rvc_mem_ctrl.sv
// +---------------------------------------------------------------------------+
// | rvc_mem_ctrl: I_MEM fetch/loader port plus a latency-modelled D_MEM port   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module rvc_mem_ctrl
  import rvc_asap_pkg::*;
#(
  parameter int I_MEM_BYTES = c_I_MEM_BYTES,
  parameter int D_MEM_BYTES = c_D_MEM_BYTES,
  parameter int RD_LAT      = c_RD_LAT
) (
  input  logic        Clock,
  input  logic        Rst,
  input  logic        FetchReq,
  input  logic [31:0] Pc,
  output logic [31:0] Instruction,
  output logic        InstValid,
  input  logic        DReq,
  input  logic        DWrEn,
  input  logic [31:0] DAddr,
  input  logic [1:0]  DSize,
  input  logic        DSignExt,
  input  logic [31:0] DWrData,
  output logic        DReady,
  output logic        DRspValid,
  output logic [31:0] DRdData,
  output logic        DFault,
  input  logic        LdEn,
  input  logic [31:0] LdAddr,
  input  logic [31:0] LdData
);

  localparam int c_IW = $clog2(I_MEM_BYTES / 4);
  localparam int c_DW = $clog2(D_MEM_BYTES / 4);

  logic [31:0]     r_imem [I_MEM_BYTES / 4];
  logic [31:0]     r_dmem [D_MEM_BYTES / 4];

  t_dmem_state     r_state;
  logic [1:0]      r_cnt;
  logic [c_DW-1:0] r_widx;
  logic [1:0]      r_lo;
  logic [1:0]      r_size;
  logic            r_sign;
  logic            r_rsp_valid;
  logic            r_fault;
  logic [31:0]     r_rdata;
  logic            r_inst_valid;
  logic [31:0]     r_inst;

  logic [c_DW-1:0] w_didx;
  logic [2:0]      w_nbytes;
  logic [32:0]     w_last;
  logic            w_fault;
  logic            w_store;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic            w_idle;
  logic [31:0]     w_ld_result;

  // Instruction side: loader wins over a same-cycle fetch.
  always_ff @(posedge Clock) begin
    if (LdEn && (LdAddr < 32'(I_MEM_BYTES)))
      r_imem[c_IW'(LdAddr >> 2)] <= LdData;
  end

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_inst_valid <= 1'b0;
      r_inst       <= '0;
    end else if (LdEn) begin
      r_inst_valid <= 1'b0;
    end else if (FetchReq) begin
      r_inst_valid <= 1'b1;
      r_inst       <= (Pc < 32'(I_MEM_BYTES)) ? r_imem[c_IW'(Pc >> 2)] : '0;
    end else begin
      r_inst_valid <= 1'b0;
    end
  end

  // Data side request decode.
  assign w_idle = (r_state == IDLE);
  assign w_didx = c_DW'((DAddr - 32'(I_MEM_BYTES)) >> 2);

  always_comb begin
    w_nbytes = 3'd4;
    w_be     = 4'hF;
    w_wdata  = DWrData;
    case (t_mem_size'(DSize))
      BYTE: begin
        w_nbytes = 3'd1;
        w_be     = 4'b0001 << DAddr[1:0];
        w_wdata  = {4{DWrData[7:0]}};
      end
      HALF: begin
        w_nbytes = 3'd2;
        w_be     = 4'b0011 << DAddr[1:0];
        w_wdata  = {2{DWrData[15:0]}};
      end
      default: begin
        w_nbytes = 3'd4;
        w_be     = 4'hF;
        w_wdata  = DWrData;
      end
    endcase
  end

  assign w_last  = {1'b0, DAddr} + 33'(w_nbytes) - 33'd1;
  assign w_fault = (DSize == 2'b11)
                 | ((DSize == 2'b01) & DAddr[0])
                 | ((DSize == 2'b10) & (|DAddr[1:0]))
                 | (DAddr < 32'(I_MEM_BYTES))
                 | (w_last > 33'(I_MEM_BYTES + D_MEM_BYTES - 1));

  // Rst gates the write so a request seen during reset never lands.
  assign w_store = Rst & DReq & w_idle & DWrEn & ~w_fault;

  always_ff @(posedge Clock) begin
    if (w_store) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_dmem[w_didx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end

  // In IDLE the load is read straight from the request; later from latched copies.
  rvc_ld_align u_ld_align (
    .raw    (r_dmem[w_idle ? w_didx : r_widx]),
    .addr   (w_idle ? DAddr[1:0] : r_lo),
    .size   (w_idle ? DSize : r_size),
    .sign   (w_idle ? DSignExt : r_sign),
    .result (w_ld_result)
  );

  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_widx      <= '0;
      r_lo        <= '0;
      r_size      <= '0;
      r_sign      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_fault     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (DReq) begin
            r_widx <= w_didx;
            r_lo   <= DAddr[1:0];
            r_size <= DSize;
            r_sign <= DSignExt;
            if (w_fault) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_fault     <= 1'b1;
              r_rdata     <= '0;
            end else if (DWrEn) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end else if (RD_LAT == 1) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rdata     <= w_ld_result;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 2'(RD_LAT > 1 ? RD_LAT - 2 : 0);
            end
          end
        end
        WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rdata     <= w_ld_result;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign DReady      = w_idle;
  assign DRspValid   = r_rsp_valid;
  assign DFault      = r_fault;
  assign DRdData     = r_rdata;
  assign InstValid   = r_inst_valid;
  assign Instruction = r_inst;

endmodule

`default_nettype wire

// File: tb/tb_rvc_mem_ctrl.sv
// +---------------------------------------------------------------------------+
// | tb_rvc_mem_ctrl: scoreboard bench driving RD_LAT=1 and RD_LAT=4 instances |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_rvc_mem_ctrl;

  localparam int c_IB = 4096;
  localparam int c_DB = 8192;

  logic        Clock = 1'b0;
  logic        Rst = 1'b1;
  logic        FetchReq = 1'b0;
  logic [31:0] Pc = '0;
  logic        DReq = 1'b0;
  logic        DWrEn = 1'b0;
  logic [31:0] DAddr = '0;
  logic [1:0]  DSize = '0;
  logic        DSignExt = 1'b0;
  logic [31:0] DWrData = '0;
  logic        LdEn = 1'b0;
  logic [31:0] LdAddr = '0;
  logic [31:0] LdData = '0;

  logic [31:0] Instruction1, Instruction4, DRdData1, DRdData4;
  logic        InstValid1, InstValid4, DReady1, DReady4;
  logic        DRspValid1, DRspValid4, DFault1, DFault4;

  always #5 Clock = ~Clock;

  rvc_mem_ctrl #(.I_MEM_BYTES(c_IB), .D_MEM_BYTES(c_DB), .RD_LAT(1)) dut1 (
    .Clock(Clock), .Rst(Rst), .FetchReq(FetchReq), .Pc(Pc),
    .Instruction(Instruction1), .InstValid(InstValid1),
    .DReq(DReq), .DWrEn(DWrEn), .DAddr(DAddr), .DSize(DSize),
    .DSignExt(DSignExt), .DWrData(DWrData), .DReady(DReady1),
    .DRspValid(DRspValid1), .DRdData(DRdData1), .DFault(DFault1),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData)
  );

  rvc_mem_ctrl #(.I_MEM_BYTES(c_IB), .D_MEM_BYTES(c_DB), .RD_LAT(4)) dut4 (
    .Clock(Clock), .Rst(Rst), .FetchReq(FetchReq), .Pc(Pc),
    .Instruction(Instruction4), .InstValid(InstValid4),
    .DReq(DReq), .DWrEn(DWrEn), .DAddr(DAddr), .DSize(DSize),
    .DSignExt(DSignExt), .DWrData(DWrData), .DReady(DReady4),
    .DRspValid(DRspValid4), .DRdData(DRdData4), .DFault(DFault4),
    .LdEn(LdEn), .LdAddr(LdAddr), .LdData(LdData)
  );

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        fault;
    logic        chkd;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q4[$];
  logic [7:0]  mem_m [longint];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] a, input logic [1:0] sz);
    longint n, lo, hi;
    if (sz == 2'b11) return 1'b1;
    n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lo = longint'(a);
    hi = lo + n - 1;
    if ((lo % n) != 0) return 1'b1;
    return (lo < c_IB) || (hi > c_IB + c_DB - 1);
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    longint     k;
    logic [7:0] b0, b1;
    k  = longint'(a);
    b0 = mem_m[k];
    if (sz == 2'b00) return sx ? {{24{b0[7]}}, b0} : {24'b0, b0};
    b1 = mem_m[k+1];
    if (sz == 2'b01) return sx ? {{16{b1[7]}}, b1, b0} : {16'b0, b1, b0};
    return {mem_m[k+3], mem_m[k+2], b1, b0};
  endfunction

  // Starts at a falling edge; returns 1 time unit after the accepting edge.
  task automatic req(input string tag, input logic wr, input logic [31:0] a,
                     input logic [1:0] sz, input logic sx, input logic [31:0] wd);
    exp_t e1, e4;
    logic f;
    int   n;
    f        = exp_fault(a, sz);
    e1.tag   = tag;
    e1.fault = f;
    e1.chkd  = f | ~wr;
    e1.data  = '0;
    if (!f && wr) begin
      n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      for (int i = 0; i < n; i++) mem_m[longint'(a) + i] = wd[8*i +: 8];
    end
    if (!f && !wr) e1.data = exp_load(a, sz, sx);
    DReq = 1'b1; DWrEn = wr; DAddr = a; DSize = sz; DSignExt = sx; DWrData = wd;
    #1;
    chk({tag, "_ready1"}, 32'(DReady1), 32'd1);
    chk({tag, "_ready4"}, 32'(DReady4), 32'd1);
    @(posedge Clock);
    #1;
    DReq = 1'b0;
    e4     = e1;
    e1.due = cyc;
    e4.due = cyc + ((f | wr) ? 0 : 3);
    q1.push_back(e1);
    q4.push_back(e4);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q1.size() != 0 || q4.size() != 0) && k < 20) begin
      @(posedge Clock);
      k++;
    end
    if (q1.size() + q4.size() != 0) begin
      chk("rsp_timeout", 32'(q1.size() + q4.size()), 32'd0);
      q1.delete();
      q4.delete();
    end
    @(negedge Clock);
  endtask

  task automatic rsp(input int lat, input logic v, input logic [31:0] rd, input logic f);
    exp_t e;
    if ((lat == 1 && q1.size() == 0) || (lat == 4 && q4.size() == 0)) begin
      chk($sformatf("unexpected_rsp_lat%0d", lat), 32'(v), 32'd0);
      return;
    end
    if (lat == 1) e = q1.pop_front();
    else          e = q4.pop_front();
    chk($sformatf("%s_lat%0d_cycle", e.tag, lat), 32'(cyc), 32'(e.due));
    chk($sformatf("%s_lat%0d_fault", e.tag, lat), 32'(f), 32'(e.fault));
    if (e.chkd) chk($sformatf("%s_lat%0d_rdata", e.tag, lat), rd, e.data);
  endtask

  always @(negedge Clock) if (DRspValid1) rsp(1, DRspValid1, DRdData1, DFault1);
  always @(negedge Clock) if (DRspValid4) rsp(4, DRspValid4, DRdData4, DFault4);

  // Starts at a falling edge and ends at the next falling edge.
  task automatic fetch(input string tag, input logic fr, input logic [31:0] pc,
                       input logic ld, input logic [31:0] la, input logic [31:0] ldd,
                       input logic ev, input logic [31:0] ei);
    FetchReq = fr; Pc = pc; LdEn = ld; LdAddr = la; LdData = ldd;
    @(posedge Clock);
    #1;
    FetchReq = 1'b0; LdEn = 1'b0;
    chk({tag, "_valid1"}, 32'(InstValid1), 32'(ev));
    chk({tag, "_valid4"}, 32'(InstValid4), 32'(ev));
    if (ev) begin
      chk({tag, "_inst1"}, Instruction1, ei);
      chk({tag, "_inst4"}, Instruction4, ei);
    end
    @(negedge Clock);
  endtask

  localparam logic [31:0] c_D = 32'(c_IB);

  initial begin
    #3 Rst = 1'b0;
    repeat (3) @(negedge Clock);
    chk("rst_instvalid1", 32'(InstValid1), 32'd0);
    chk("rst_instvalid4", 32'(InstValid4), 32'd0);
    chk("rst_inst1", Instruction1, 32'd0);
    chk("rst_inst4", Instruction4, 32'd0);
    chk("rst_rspvalid1", 32'(DRspValid1), 32'd0);
    chk("rst_rspvalid4", 32'(DRspValid4), 32'd0);
    chk("rst_fault1", 32'(DFault1), 32'd0);
    chk("rst_fault4", 32'(DFault4), 32'd0);
    chk("rst_rdata1", DRdData1, 32'd0);
    chk("rst_rdata4", DRdData4, 32'd0);
    chk("rst_ready1", 32'(DReady1), 32'd1);
    chk("rst_ready4", 32'(DReady4), 32'd1);

    // First request lands on the first rising edge after release.
    Rst = 1'b1;
    req("st_w4", 1'b1, c_D + 4, 2'b10, 1'b0, 32'h8081_F0F1);
    wait_idle();

    fetch("ld_fetch_drop", 1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
    fetch("fetch_10", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    fetch("ld_only", 1'b0, 32'h0, 1'b1, c_D - 4, 32'h1357_9BDF, 1'b0, 32'h0);
    fetch("fetch_top", 1'b1, c_D - 4, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1357_9BDF);
    fetch("fetch_oob", 1'b1, c_D, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    fetch("idle_fetch", 1'b0, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

    req("lb_s5", 1'b0, c_D + 5, 2'b00, 1'b1, 32'h0);        wait_idle();
    req("lb_z5", 1'b0, c_D + 5, 2'b00, 1'b0, 32'h0);        wait_idle();
    req("lw_4", 1'b0, c_D + 4, 2'b10, 1'b0, 32'h0);         wait_idle();
    req("sh_6", 1'b1, c_D + 6, 2'b01, 1'b0, 32'hFFFF_1234); wait_idle();
    req("lw_4b", 1'b0, c_D + 4, 2'b10, 1'b1, 32'h0);        wait_idle();
    req("lh_s4", 1'b0, c_D + 4, 2'b01, 1'b1, 32'h0);        wait_idle();
    req("lb_s7", 1'b0, c_D + 7, 2'b00, 1'b1, 32'h0);        wait_idle();

    req("f_lw6", 1'b0, c_D + 6, 2'b10, 1'b0, 32'h0);              wait_idle();
    req("f_lh5", 1'b0, c_D + 5, 2'b01, 1'b1, 32'h0);              wait_idle();
    req("f_sz3", 1'b0, c_D + 4, 2'b11, 1'b0, 32'h0);              wait_idle();
    req("f_sw_end", 1'b1, 32'(c_IB + c_DB - 1), 2'b10, 1'b0, 32'h0); wait_idle();
    req("f_lb_low", 1'b0, c_D - 1, 2'b00, 1'b0, 32'h0);           wait_idle();
    req("f_sw6", 1'b1, c_D + 6, 2'b10, 1'b0, 32'hFFFF_FFFF);      wait_idle();
    req("lw_4c", 1'b0, c_D + 4, 2'b10, 1'b0, 32'h0);              wait_idle();

    req("sb_end", 1'b1, 32'(c_IB + c_DB - 1), 2'b00, 1'b0, 32'h0000_009C); wait_idle();
    req("lb_end", 1'b0, 32'(c_IB + c_DB - 1), 2'b00, 1'b1, 32'h0);         wait_idle();
    req("sw_top", 1'b1, 32'(c_IB + c_DB - 4), 2'b10, 1'b0, 32'hA5C3_7E01); wait_idle();
    req("lh_top", 1'b0, 32'(c_IB + c_DB - 2), 2'b01, 1'b0, 32'h0);         wait_idle();

    // Reset while the RD_LAT=4 instance sits in WAIT: that response must never appear.
    req("lb_rst", 1'b0, c_D + 4, 2'b00, 1'b0, 32'h0);
    @(negedge Clock);
    #2;
    Rst = 1'b0;
    q4.delete();
    #1;
    chk("rst_wait_ready4", 32'(DReady4), 32'd1);
    chk("rst_wait_rspvalid4", 32'(DRspValid4), 32'd0);
    repeat (2) @(negedge Clock);
    Rst = 1'b1;
    repeat (8) @(negedge Clock);
    chk("post_rst_ready1", 32'(DReady1), 32'd1);
    chk("post_rst_ready4", 32'(DReady4), 32'd1);
    chk("post_rst_q1_drained", 32'(q1.size()), 32'd0);
    req("lw_after_rst", 1'b0, c_D + 4, 2'b10, 1'b0, 32'h0);
    wait_idle();
    repeat (2) @(negedge Clock);
    chk("rdata_hold1", DRdData1, 32'h1234_F0F1);
    chk("rdata_hold4", DRdData4, 32'h1234_F0F1);
    chk("idle_fault1", 32'(DFault1), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/rvc_mem_ctrl.md
RVC_MEM_CTRL -- requirements
Module: rvc_mem_ctrl

Interface
REQ-001 Parameter I_MEM_BYTES, default 4096: I_MEM size in bytes, covering addresses 0..I_MEM_BYTES-1, multiple of 4.
REQ-002 Parameter D_MEM_BYTES, default 8192: D_MEM size in bytes, covering addresses I_MEM_BYTES..I_MEM_BYTES+D_MEM_BYTES-1, multiple of 4.
REQ-003 Parameter RD_LAT, default 2, legal 1..4: D_MEM load latency in cycles from accepted request to DRspValid.
REQ-004 Clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Rst  in  1  reset, asynchronous assert, active-low.
REQ-006 FetchReq  in  1  fetch request for the word at Pc.
REQ-007 Pc  in  32  fetch byte address, word aligned.
REQ-008 Instruction  out  32  fetched word, little-endian.
REQ-009 InstValid  out  1  Instruction valid this cycle.
REQ-010 DReq  in  1  data request, qualified by DReady.
REQ-011 DWrEn  in  1  1 = store, 0 = load.
REQ-012 DAddr  in  32  data byte address.
REQ-013 DSize  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
REQ-014 DSignExt  in  1  load sign-extend (1) or zero-extend (0).
REQ-015 DWrData  in  32  store data, right-justified.
REQ-016 DReady  out  1  controller can accept a data request.
REQ-017 DRspValid  out  1  one-cycle completion pulse per accepted request.
REQ-018 DRdData  out  32  load result, right-justified and extended.
REQ-019 DFault  out  1  the accepted request faulted; qualified by DRspValid.
REQ-020 LdEn  in  1  external I_MEM word write (program loader).
REQ-021 LdAddr  in  32  loader byte address, word aligned.
REQ-022 LdData  in  32  loader word.

Function
REQ-023 Fetch: FetchReq with LdEn=0 in cycle N gives InstValid=1 and Instruction=I_MEM[Pc..Pc+3] in cycle N+1.
REQ-024 Loader priority: LdEn=1 writes LdData to I_MEM[LdAddr..+3] at the edge; a same-cycle FetchReq is dropped, so InstValid=0 next cycle.
REQ-025 Fetch or load with address >= I_MEM_BYTES: no write; InstValid=1 with Instruction=0.
REQ-026 Data FSM states: IDLE, WAIT, RESP; DReady=1 only in IDLE.
REQ-027 Acceptance: DReq&&DReady latches DAddr, DSize, DSignExt, DWrEn and DWrData.
REQ-028 Fault check: fault if DSize=11, a half access has DAddr[0]=1, a word access has DAddr[1:0]!=0, or any accessed byte is outside the D_MEM range.
REQ-029 A faulted request does not modify memory; it goes IDLE->RESP, giving DRspValid=1 and DFault=1 one cycle after acceptance, with DRdData=0.
REQ-030 A legal store writes only the 1/2/4 addressed bytes from DWrData[7:0]/[15:0]/[31:0] on the acceptance edge, then goes IDLE->RESP, giving DRspValid one cycle after acceptance.
REQ-031 Legal load, RD_LAT=1: IDLE->RESP.
REQ-032 Legal load, RD_LAT>1: IDLE->WAIT; a down-counter loaded with RD_LAT-2 holds WAIT until it reaches 0, then goes to RESP, so DRspValid comes exactly RD_LAT cycles after acceptance.
REQ-033 Load data is the D_MEM bytes read in the RESP-entry cycle, right-justified and sign- or zero-extended from bit 7/15 per the latched DSignExt; a word load is not extended.
REQ-034 RESP lasts one cycle, then goes to IDLE; back-to-back requests therefore have at least one idle cycle between them.
REQ-035 Outside RESP: DRspValid=0, DFault=0, DRdData holds its last value.
REQ-036 D_MEM is written only via the data port; I_MEM is written only via the loader.

Reset
REQ-037 Rst=0 forces immediately: FSM=IDLE, counter=0, InstValid=0, Instruction=0, DRspValid=0, DFault=0, DRdData=0.
REQ-038 Reset mid-transaction aborts it with no response; memory array contents are not reset.
REQ-039 The first request is accepted on the first rising edge after Rst deasserts.

Structure
REQ-040 rvc_asap_pkg holds t_mem_size (BYTE, HALF, WORD), t_dmem_state (IDLE, WAIT, RESP), and the I_MEM_BYTES/D_MEM_BYTES/RD_LAT defaults.
REQ-041 Load extraction and extension is one combinational sub-module, rvc_ld_align (inputs: raw word, addr[1:0], size, sign; output: result).

Verification
REQ-042 Loader writes 0xDEADBEEF to 0x10; fetch Pc=0x10 next cycle -> InstValid=1 and Instruction=0xDEADBEEF one cycle later; a fetch issued together with LdEn -> InstValid=0.
REQ-043 Word store 0x8081_F0F1 at I_MEM_BYTES+4; byte load at +5, DSignExt=1 -> DRdData=0xFFFFFFF0; DSignExt=0 -> 0x000000F0; DRspValid exactly RD_LAT cycles after accept, for RD_LAT=1 and RD_LAT=4.
REQ-044 Half store at offset 2 (0x1234) -> the other two bytes are unchanged and a word load returns 0x1234_F0F1.
REQ-045 Word load at offset 2, half at offset 1, DSize=11, and a word at the last D_MEM byte -> each gives DFault=1 with DRspValid one cycle after accept and no memory change.
REQ-046 Assert Rst during WAIT -> DRspValid is never asserted for that request, DReady=1 after reset, and memory contents are intact.
